// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-in / parallel-out bundle of the UART receiver.
//   RxD        serial line, idle high (driver -> receiver)
//   SampleTick one-clk pulse at OVERSAMPLE x baud (driver -> receiver)
//   RxD_data   last correctly received word
//   RxD_valid  one-clk pulse, RxD_data updated
//   FrameErr   last completed frame had a low stop bit
//   Busy       receiver is inside a frame
interface uart_rx_if #(parameter int BITS = 8);
    logic            RxD;
    logic            SampleTick;
    logic [BITS-1:0] RxD_data;
    logic            RxD_valid;
    logic            FrameErr;
    logic            Busy;
    modport master (output RxD, SampleTick, input RxD_data, RxD_valid, FrameErr, Busy);
    modport slave  (input RxD, SampleTick, output RxD_data, RxD_valid, FrameErr, Busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 1 start + BITS data (LSB first) + 1 stop, no parity.
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  uart_rx_if.slave: RxD, SampleTick in; RxD_data, RxD_valid, FrameErr, Busy out
module uart_rx #(
    parameter int BITS       = 8,
    parameter int OVERSAMPLE = 16
) (
    input logic     clk,
    input logic     rst,
    uart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(BITS + 1);
    localparam logic [TW-1:0] HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t          state, state_n;
    logic [1:0]      sync;
    logic            rxs;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [BITS-1:0] sh, sh_n, data, data_n;
    logic            valid, valid_n, ferr, ferr_n;

    assign rxs = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            state <= S_IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            sh    <= '0;
            data  <= '0;
            valid <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            sync  <= {sync[0], bus.RxD};
            state <= state_n;
            tcnt  <= tcnt_n;
            bcnt  <= bcnt_n;
            sh    <= sh_n;
            data  <= data_n;
            valid <= valid_n;
            ferr  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        bcnt_n  = bcnt;
        sh_n    = sh;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = ferr;
        case (state)
            S_IDLE: if (!rxs) begin
                state_n = S_START;
                tcnt_n  = '0;
            end
            // Re-check the line at mid start bit to reject glitches.
            S_START: if (bus.SampleTick) begin
                tcnt_n = tcnt + 1'b1;
                if (tcnt == HALF) begin
                    state_n = rxs ? S_IDLE : S_DATA;
                    tcnt_n  = '0;
                    bcnt_n  = '0;
                end
            end
            // Sampling a full bit period after mid start lands on mid data bit.
            S_DATA: if (bus.SampleTick) begin
                tcnt_n = tcnt + 1'b1;
                if (tcnt == LAST) begin
                    sh_n   = {rxs, sh[BITS-1:1]};
                    tcnt_n = '0;
                    bcnt_n = bcnt + 1'b1;
                    if (bcnt == BLAST) state_n = S_STOP;
                end
            end
            S_STOP: if (bus.SampleTick) begin
                tcnt_n = tcnt + 1'b1;
                if (tcnt == LAST) begin
                    tcnt_n  = '0;
                    state_n = rxs ? S_IDLE : S_BREAK;
                    ferr_n  = !rxs;
                    valid_n = rxs;
                    data_n  = rxs ? sh : data;
                end
            end
            // A held-low line must not be mistaken for a new start bit.
            S_BREAK: if (rxs) begin
                state_n = S_IDLE;
                tcnt_n  = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.RxD_data  = data;
    assign bus.RxD_valid = valid;
    assign bus.FrameErr  = ferr;
    assign bus.Busy      = state != S_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (BITS=8, OVERSAMPLE=16, tick every 4 clk).
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int dbl = 0;
    logic vprev = 1'b0;
    logic ferr_seen = 1'b0;
    logic [1:0] tdiv = 2'd0;
    logic [7:0] q[$];
    logic [7:0] b;

    uart_rx_if #(.BITS(8)) bus ();
    uart_rx #(.BITS(8), .OVERSAMPLE(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial forever #5 clk = ~clk;

    initial begin
        bus.SampleTick = 1'b0;
        forever begin
            @(negedge clk);
            tdiv = tdiv + 2'd1;
            bus.SampleTick = (tdiv == 2'd0);
        end
    end

    always @(negedge clk) begin
        if (bus.RxD_valid) begin
            q.push_back(bus.RxD_data);
            if (vprev) dbl <= dbl + 1;
        end
        if (bus.FrameErr) ferr_seen <= 1'b1;
        vprev <= bus.RxD_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!bus.SampleTick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        bus.RxD = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            bus.RxD = d[i];
            wait_ticks(16);
        end
        bus.RxD = stop;
        wait_ticks(16);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        if (q.size() == 0) check({tag, "_missing"}, 0, 1);
        else check(tag, q.pop_front(), exp);
    endtask

    initial begin
        bus.RxD = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", bus.RxD_data, 0);
        check("rst_valid", bus.RxD_valid, 0);
        check("rst_ferr", bus.FrameErr, 0);
        check("rst_busy", bus.Busy, 0);
        rst = 1'b0;
        wait_ticks(20);

        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (100) @(negedge clk);
                check("a5_busy_mid", bus.Busy, 1);
            end
        join
        expect_byte("a5_data", 8'hA5);
        check("a5_ferr", bus.FrameErr, 0);
        wait_ticks(4);
        check("a5_busy_end", bus.Busy, 0);
        check("a5_reg", bus.RxD_data, 8'hA5);

        bus.RxD = 1'b0;
        wait_ticks(3);
        bus.RxD = 1'b1;
        wait_ticks(8);
        check("glitch_busy", bus.Busy, 0);
        check("glitch_novalid", q.size(), 0);
        check("glitch_ferr", bus.FrameErr, 0);
        send_frame(8'h5A, 1'b1);
        expect_byte("5a_data", 8'h5A);
        wait_ticks(8);

        send_frame(8'h3C, 1'b0);
        wait_ticks(32);
        check("brk_busy", bus.Busy, 1);
        check("brk_ferr", bus.FrameErr, 1);
        wait_ticks(48);
        bus.RxD = 1'b1;
        wait_ticks(32);
        check("brk_ferr_hold", bus.FrameErr, 1);
        check("brk_data_keep", bus.RxD_data, 8'h5A);
        check("brk_novalid", q.size(), 0);
        check("brk_busy_end", bus.Busy, 0);
        send_frame(8'h81, 1'b1);
        expect_byte("81_data", 8'h81);
        check("81_ferr_clr", bus.FrameErr, 0);
        wait_ticks(8);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h01, 1'b1);
        expect_byte("b2b_0", 8'h00);
        expect_byte("b2b_1", 8'hFF);
        expect_byte("b2b_2", 8'h01);
        check("b2b_ferr", bus.FrameErr, 0);
        wait_ticks(8);

        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_ticks(16 * 5 + 8);
                @(negedge clk);
                #2 rst = 1'b1;
                #1;
                check("arst_data", bus.RxD_data, 0);
                check("arst_valid", bus.RxD_valid, 0);
                check("arst_ferr", bus.FrameErr, 0);
                check("arst_busy", bus.Busy, 0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        check("arst_novalid", q.size(), 0);
        wait_ticks(8);
        send_frame(8'h7E, 1'b1);
        expect_byte("7e_data", 8'h7E);
        wait_ticks(8);

        ferr_seen = 1'b0;
        for (int i = 0; i < 48; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            expect_byte("loop", b);
        end
        wait_ticks(8);
        check("loop_ferr", ferr_seen, 0);
        check("no_extra", q.size(), 0);
        check("valid_single", dbl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
